// File: rtl/dvp_source.sv
// dvp_source: transmit side of the camera parallel pixel bus.
// Turns an RGB565 pixel stream into free-running vsync/href/p_data frames.
// Optional feature macro: DVP_TEST_PATTERN_EN builds an 8-bar colour test
// pattern selected per frame by tpg_sel; without it tpg_sel is ignored.
module dvp_source #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned VBP_LINES   = 17
) (
   input  logic        p_clock,
   input  logic        rst,
   input  logic        enable,
   input  logic        tpg_sel,
   input  logic [15:0] pix_in,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  p_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        underflow
);

   localparam int unsigned HREF_LEN  = 2 * H_ACTIVE;
   localparam int unsigned LINE_LEN  = HREF_LEN + H_BLANK;
   localparam int unsigned HW        = $clog2(LINE_LEN);
   localparam int unsigned MAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
   localparam int unsigned MAX_LINES = (MAX_A > V_ACTIVE) ? MAX_A : V_ACTIVE;
   localparam int unsigned LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_VSYNC  = 2'd1,
      S_VBP    = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   // Frame position: phase, cycle within line, line within phase.
   typedef struct packed {
      state_t          state;
      logic [HW-1:0]   hcnt;
      logic [LW-1:0]   lcnt;
   } pos_t;

   // Advance a frame position by one cycle.
   function automatic pos_t step(input pos_t p, input logic en);
      pos_t n;
      logic eol;
      logic last_line;
      n   = p;
      eol = (p.hcnt == HW'(LINE_LEN - 1));
      case (p.state)
         S_VSYNC:  last_line = (p.lcnt == LW'(VSYNC_LINES - 1));
         S_VBP:    last_line = (p.lcnt == LW'(VBP_LINES - 1));
         S_ACTIVE: last_line = (p.lcnt == LW'(V_ACTIVE - 1));
         default:  last_line = 1'b0;
      endcase
      if (p.state == S_IDLE) begin
         n = '0;
         if (en) n.state = S_VSYNC;
      end else if (!eol) begin
         n.hcnt = p.hcnt + HW'(1);
      end else begin
         n.hcnt = '0;
         if (!last_line) begin
            n.lcnt = p.lcnt + LW'(1);
         end else begin
            n.lcnt = '0;
            case (p.state)
               S_VSYNC: n.state = S_VBP;
               S_VBP:   n.state = S_ACTIVE;
               default: n.state = en ? S_VSYNC : S_IDLE;
            endcase
         end
      end
      return n;
   endfunction

   // High-byte cycle of a pixel slot.
   function automatic logic is_hi(input state_t s, input logic [HW-1:0] h);
      return (s == S_ACTIVE) && (h < HW'(HREF_LEN)) && !h[0];
   endfunction

   // Low-byte cycle of a pixel slot.
   function automatic logic is_lo(input state_t s, input logic [HW-1:0] h);
      return (s == S_ACTIVE) && (h < HW'(HREF_LEN)) && h[0];
   endfunction

`ifdef DVP_TEST_PATTERN_EN
   // Colour of the vertical bar covering the pixel at byte position h.
   function automatic logic [15:0] bar_color(input logic [HW-1:0] h);
      int unsigned bar;
      bar = ((32'(h) >> 1) * 32'd8) / H_ACTIVE;
      case (bar)
         0:       return 16'hFFFF;
         1:       return 16'hFFE0;
         2:       return 16'h07FF;
         3:       return 16'h07E0;
         4:       return 16'hF81F;
         5:       return 16'hF800;
         6:       return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction
`endif

   pos_t        cur;
   pos_t        nxt;
   pos_t        nn;
   logic [7:0]  lo_byte;
   logic [7:0]  lo_byte_nxt;
   logic [15:0] pix_word;
   logic        take;
   logic        tpg_on;
   logic        pix_ready_nxt;
   logic        vsync_nxt;
   logic        href_nxt;
   logic [7:0]  p_data_nxt;
   logic        frame_start_nxt;
   logic        frame_done_nxt;
   logic        underflow_nxt;

`ifdef DVP_TEST_PATTERN_EN
   logic        tpg_frame;
   logic        tpg_nxt;
`else
   logic        unused_tpg_sel;
   assign unused_tpg_sel = tpg_sel;
`endif

   // Next position, lookahead for pix_ready, and next registered outputs.
   always_comb begin
      nxt             = step(cur, enable);
      nn              = step(nxt, enable);
      take            = pix_ready && pix_valid;
      frame_start_nxt = (nxt.state == S_VSYNC) && (cur.state != S_VSYNC);
`ifdef DVP_TEST_PATTERN_EN
      tpg_nxt  = frame_start_nxt ? tpg_sel : tpg_frame;
      tpg_on   = tpg_frame;
      pix_word = tpg_frame ? bar_color(nxt.hcnt) : (take ? pix_in : 16'h0000);
`else
      tpg_on   = 1'b0;
      pix_word = take ? pix_in : 16'h0000;
`endif
      vsync_nxt      = (nxt.state == S_VSYNC);
      href_nxt       = (nxt.state == S_ACTIVE) && (nxt.hcnt < HW'(HREF_LEN));
      p_data_nxt     = 8'h00;
      lo_byte_nxt    = lo_byte;
      if (is_hi(nxt.state, nxt.hcnt)) begin
         p_data_nxt  = pix_word[15:8];
         lo_byte_nxt = pix_word[7:0];
      end else if (is_lo(nxt.state, nxt.hcnt)) begin
         p_data_nxt  = lo_byte;
      end
`ifdef DVP_TEST_PATTERN_EN
      pix_ready_nxt  = is_hi(nn.state, nn.hcnt) && !tpg_nxt;
`else
      pix_ready_nxt  = is_hi(nn.state, nn.hcnt) && !tpg_on;
`endif
      frame_done_nxt = is_lo(nxt.state, nxt.hcnt)
                       && (nxt.lcnt == LW'(V_ACTIVE - 1))
                       && (nxt.hcnt == HW'(HREF_LEN - 1));
      underflow_nxt  = underflow || (pix_ready && !pix_valid);
   end

   // State, counters and all outputs.
   always_ff @(posedge p_clock) begin
      if (rst) begin
         cur         <= '0;
         lo_byte     <= 8'h00;
         pix_ready   <= 1'b0;
         vsync       <= 1'b0;
         href        <= 1'b0;
         p_data      <= 8'h00;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         cur         <= nxt;
         lo_byte     <= lo_byte_nxt;
         pix_ready   <= pix_ready_nxt;
         vsync       <= vsync_nxt;
         href        <= href_nxt;
         p_data      <= p_data_nxt;
         frame_start <= frame_start_nxt;
         frame_done  <= frame_done_nxt;
         underflow   <= underflow_nxt;
      end
   end

`ifdef DVP_TEST_PATTERN_EN
   // Pattern select is latched at each frame start.
   always_ff @(posedge p_clock) begin
      if (rst) tpg_frame <= 1'b0;
      else     tpg_frame <= tpg_nxt;
   end
`endif

endmodule
